tt_um_array_multiplier_hhrb98: RTL and testbench

TT_UM_ARRAY_MULTIPLIER_HHRB98 -- requirements
Module: tt_um_array_multiplier_hhrb98

---
 rtl/array_mult_pkg.sv | 6 +
 rtl/array_mult_fa.sv | 13 +
 rtl/tt_um_array_multiplier_hhrb98.sv | 85 ++++++++
 tb/tb_tt_um_array_multiplier_hhrb98.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/array_mult_pkg.sv
// array_mult_pkg: shared widths and reset value for the 4x4 array multiplier.
package array_mult_pkg;
    localparam int OPW = 4;
    localparam int PW = 8;
    localparam logic [PW-1:0] PROD_RST = 8'h00;
endpackage

// File: rtl/array_mult_fa.sv
// array_mult_fa: 1-bit full adder cell; half-adder positions tie cin low.
module array_mult_fa
    import array_mult_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/tt_um_array_multiplier_hhrb98.sv
// tt_um_array_multiplier_hhrb98: registered 4x4 carry-save array multiplier.
// Define ARRAY_MULT_SIGNED_EN to add Baugh-Wooley signed mode on uio_in[0].
module tt_um_array_multiplier_hhrb98
    import array_mult_pkg::*;
#(
    parameter int N = OPW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [7:0]    ui_in,
    input  logic [7:0]    uio_in,
    output logic [PW-1:0] uo_out,
    output logic [7:0]    uio_out,
    output logic [7:0]    uio_oe
);
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_b;
    logic           w_corr;
    logic           w_pp [N][N];
    logic           w_s [N][N+1];
    logic           w_c [N][N];
    logic           w_r [N+1];
    logic [2*N-1:0] w_prod;
    logic           w_unused;
    logic [PW-1:0]  r_prod;
    assign w_a = ui_in[N-1:0];
    assign w_b = ui_in[2*N-1:N];
`ifdef ARRAY_MULT_SIGNED_EN
    assign w_corr = uio_in[0];
`else
    assign w_corr = 1'b0;
`endif
    for (genvar i = 0; i < N; i++) begin : g_pp_row
        for (genvar j = 0; j < N; j++) begin : g_pp_col
`ifdef ARRAY_MULT_SIGNED_EN
            // Baugh-Wooley: invert cross terms involving exactly one sign bit
            localparam bit INV = (i == N-1) != (j == N-1);
            assign w_pp[i][j] = (w_a[j] & w_b[i]) ^ (w_corr & INV);
`else
            assign w_pp[i][j] = w_a[j] & w_b[i];
`endif
        end
    end
    for (genvar j = 0; j < N; j++) begin : g_row0
        assign w_s[0][j] = w_pp[0][j];
        assign w_c[0][j] = 1'b0;
    end
    // Spare sum slots carry the +2^N and +2^(2N-1) sign-correction constants
    for (genvar i = 0; i < N; i++) begin : g_edge
        assign w_s[i][N] = (i == 0 || i == N-1) ? w_corr : 1'b0;
        assign w_prod[i] = w_s[i][0];
    end
    for (genvar i = 1; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            array_mult_fa u_fa (
                .a    (w_pp[i][j]),
                .b    (w_s[i-1][j+1]),
                .cin  (w_c[i-1][j]),
                .sum  (w_s[i][j]),
                .cout (w_c[i][j])
            );
        end
    end
    assign w_r[0] = 1'b0;
    for (genvar k = 0; k < N; k++) begin : g_rip
        array_mult_fa u_fa (
            .a    (w_s[N-1][k+1]),
            .b    (w_c[N-1][k]),
            .cin  (w_r[k]),
            .sum  (w_prod[N+k]),
            .cout (w_r[k+1])
        );
    end
    assign w_unused = ^{uio_in, w_r[N]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_prod <= PROD_RST;
        else if (ena)
            r_prod <= w_prod;
    end
    assign uo_out = r_prod;
    assign uio_out = 8'h00;
    assign uio_oe = 8'h00;
endmodule

// File: tb/tb_tt_um_array_multiplier_hhrb98.sv
// tb_tt_um_array_multiplier_hhrb98: directed and exhaustive checks of the array multiplier.
module tb_tt_um_array_multiplier_hhrb98;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    int checks = 0;
    int errors = 0;

    tt_um_array_multiplier_hhrb98 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [7:0] v, input logic [7:0] exp, input string name);
        @(negedge clk);
        ui_in = v;
        @(posedge clk);
        #1;
        checks++;
        if (uo_out !== exp) begin
            errors++;
            $display("FAIL %s: uo_out=%h expected %h", name, uo_out, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ena = 1'b1;
        ui_in = 8'hFF;
        uio_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_out: got %h expected 00", uio_out);
        end
        if (uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_oe: got %h expected 00", uio_oe);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (uo_out !== 8'hE1) begin
            errors++;
            $display("FAIL first_edge: got %h expected E1", uo_out);
        end
    endtask

    task automatic test_unsigned;
        uio_in = 8'hFE;
        load(8'h53, 8'h0F, "u_3x5");
        ui_in = 8'hFF;
        @(negedge clk);
        checks++;
        if (uo_out !== 8'h0F) begin
            errors++;
            $display("FAIL no_comb_path: got %h expected 0F", uo_out);
        end
        load(8'h70, 8'h00, "u_0x7");
        load(8'h1F, 8'h0F, "u_15x1");
        load(8'hA4, 8'h28, "u_4x10");
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL uio_const: uio_out=%h uio_oe=%h expected 00 00", uio_out, uio_oe);
        end
        uio_in = 8'h00;
    endtask

    task automatic test_exhaustive;
        logic [7:0] prev;
        logic [7:0] exp;
        uio_in = 8'h00;
        for (int v = 0; v <= 256; v++) begin
            @(negedge clk);
            if (v > 0) begin
                prev = 8'(v - 1);
                exp = 8'(int'(prev[3:0]) * int'(prev[7:4]));
                checks++;
                if (uo_out !== exp) begin
                    errors++;
                    $display("FAIL exhaustive ui_in=%h: got %h expected %h", prev, uo_out, exp);
                end
            end
            if (v < 256)
                ui_in = 8'(v);
        end
    endtask

    task automatic test_enable_hold;
        load(8'h53, 8'h0F, "hold_load");
        @(negedge clk);
        ena = 1'b0;
        ui_in = 8'hFF;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (uo_out !== 8'h0F) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %h expected 0F", n, uo_out);
            end
        end
        @(negedge clk);
        ena = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (uo_out !== 8'hE1) begin
            errors++;
            $display("FAIL hold_release: got %h expected E1", uo_out);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %h expected 00", uo_out);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (uo_out !== 8'hE1) begin
            errors++;
            $display("FAIL post_async_reset: got %h expected E1", uo_out);
        end
    endtask

`ifdef ARRAY_MULT_SIGNED_EN
    task automatic test_signed;
        uio_in = 8'h01;
        load(8'h88, 8'h40, "s_m8xm8");
        load(8'h7F, 8'hF9, "s_m1x7");
        load(8'h87, 8'hC8, "s_7xm8");
        uio_in = 8'h00;
        load(8'h88, 8'h40, "u_8x8");
        load(8'h7F, 8'h69, "u_15x7");
        load(8'h87, 8'h38, "u_7x8");
    endtask
`endif

    initial begin
        test_reset;
        test_unsigned;
        test_exhaustive;
        test_enable_hold;
        test_async_reset;
`ifdef ARRAY_MULT_SIGNED_EN
        test_signed;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
